// File: rtl/timer_display_ctrl.sv
`timescale 1ns/1ps
// Two-digit multiplexed active-low 7-segment driver for the countdown timer; blinks "00" after expiry.
// Latency: inputs reach seg/an in 2 clocks, time_up follows the sampled running drop by 1 clock; no backpressure.
module timer_display_ctrl #(
  parameter int SCAN_DIV    = 50000,
  parameter int BLINK_DIV   = 25000000,
  parameter int BLINK_COUNT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] tens_in,
  input  logic [3:0] ones_in,
  input  logic       running,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       time_up,
  output logic       blinking
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int CW = $clog2(BLINK_COUNT + 1);

  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [CW-1:0] CYC_LAST   = CW'(BLINK_COUNT - 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ZERO  = 7'b0000001;
  localparam logic [1:0] AN_OFF    = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    BLINK
  } state_t;

  state_t        state;
  logic [3:0]    d1_tens;
  logic [3:0]    d1_ones;
  logic          d1_run;
  logic          d2_run;
  logic [SW-1:0] scan_cnt;
  logic          sel;
  logic [BW-1:0] blink_cnt;
  logic          blink_on;
  logic [CW-1:0] cycles;

  logic [6:0]    live_seg;
  logic [1:0]    live_an;
  logic          digits_zero;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b0000001;
      4'd1:    decode = 7'b1001111;
      4'd2:    decode = 7'b0010010;
      4'd3:    decode = 7'b0000110;
      4'd4:    decode = 7'b1001100;
      4'd5:    decode = 7'b0100100;
      4'd6:    decode = 7'b0100000;
      4'd7:    decode = 7'b0001111;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0000100;
      default: decode = 7'b1111110;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d1_tens <= 4'd0;
      d1_ones <= 4'd0;
      d1_run  <= 1'b0;
      d2_run  <= 1'b0;
    end else begin
      d1_tens <= tens_in;
      d1_ones <= ones_in;
      d1_run  <= running;
      d2_run  <= d1_run;
    end
  end

  // Digit scan runs free in every state so the blink "on" phase stays multiplexed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      sel      <= 1'b0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      sel      <= ~sel;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  always_comb begin
    live_seg    = decode(sel ? d1_tens : d1_ones);
    live_an     = sel ? 2'b01 : 2'b10;
    digits_zero = (d1_tens == 4'd0) && (d1_ones == 4'd0);
  end

  // Display registers are written alongside the state so the first blank frame lands on the BLINK entry edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      blink_cnt <= '0;
      blink_on  <= 1'b0;
      cycles    <= '0;
      time_up   <= 1'b0;
      seg       <= SEG_BLANK;
      an        <= AN_OFF;
    end else begin
      time_up <= 1'b0;
      seg     <= live_seg;
      an      <= live_an;
      case (state)
        IDLE: begin
          if (d1_run) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (!d1_run) begin
            if (d2_run && digits_zero) begin
              state     <= BLINK;
              time_up   <= 1'b1;
              blink_cnt <= '0;
              blink_on  <= 1'b0;
              cycles    <= '0;
              seg       <= SEG_BLANK;
              an        <= AN_OFF;
            end else begin
              state <= IDLE;
            end
          end
        end
        BLINK: begin
          if (d1_run) begin
            // A new round pre-empts the blink, including on its final edge.
            state     <= RUN;
            blink_cnt <= '0;
            blink_on  <= 1'b0;
            cycles    <= '0;
          end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blink_on  <= ~blink_on;
            if (!blink_on) begin
              seg <= SEG_ZERO;
            end else if (cycles == CYC_LAST) begin
              state    <= IDLE;
              blink_on <= 1'b0;
              cycles   <= '0;
            end else begin
              cycles <= cycles + 1'b1;
              seg    <= SEG_BLANK;
              an     <= AN_OFF;
            end
          end else begin
            blink_cnt <= blink_cnt + 1'b1;
            if (blink_on) begin
              seg <= SEG_ZERO;
            end else begin
              seg <= SEG_BLANK;
              an  <= AN_OFF;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign blinking = (state == BLINK);

endmodule

// File: tb/tb_timer_display_ctrl.sv
`timescale 1ns/1ps
// Bench for timer_display_ctrl: directed stimulus pushes per-cycle expected outputs, a monitor pops and compares.
module tb_timer_display_ctrl;

  typedef struct packed {
    int         cyc;
    logic [6:0] seg;
    logic [1:0] an;
    logic       tu;
    logic       bl;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] tens_in;
  logic [3:0] ones_in;
  logic       running;
  logic [6:0] seg;
  logic [1:0] an;
  logic       time_up;
  logic       blinking;

  int    cyc = 0;
  int    total = 0;
  int    bad = 0;
  int    scan_ref = 0;
  exp_t  exp_q[$];
  string name_q[$];
  logic [7:0] vec [6];

  timer_display_ctrl #(
    .SCAN_DIV(4),
    .BLINK_DIV(8),
    .BLINK_COUNT(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tens_in(tens_in),
    .ones_in(ones_in),
    .running(running),
    .seg(seg),
    .an(an),
    .time_up(time_up),
    .blinking(blinking)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [6:0] dec(input logic [3:0] d);
    case (d)
      4'd0:    dec = 7'b0000001;
      4'd1:    dec = 7'b1001111;
      4'd2:    dec = 7'b0010010;
      4'd3:    dec = 7'b0000110;
      4'd4:    dec = 7'b1001100;
      4'd5:    dec = 7'b0100100;
      4'd6:    dec = 7'b0100000;
      4'd7:    dec = 7'b0001111;
      4'd8:    dec = 7'b0000000;
      4'd9:    dec = 7'b0000100;
      default: dec = 7'b1111110;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int c, input logic [6:0] s, input logic [1:0] a,
                      input logic tu, input logic bl, input string nm);
    exp_t e;
    e.cyc = c; e.seg = s; e.an = a; e.tu = tu; e.bl = bl;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Slot of the output at edge e: 4-clock slots counted from the edge after reset release, ones first.
  task automatic push_live(input int from, input int to, input logic [3:0] t, input logic [3:0] o,
                           input logic bl, input string nm);
    for (int e = from; e <= to; e++) begin
      int s;
      s = ((e - scan_ref - 1) / 4) % 2;
      push(e, dec((s != 0) ? t : o), (s != 0) ? 2'b01 : 2'b10, 1'b0, bl, nm);
    end
  endtask

  task automatic push_blank(input int from, input int to, input logic bl, input string nm);
    for (int e = from; e <= to; e++) push(e, 7'b1111111, 2'b11, 1'b0, bl, nm);
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < 500) begin
      tick(1);
      i++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expected entries never reached, required 0", exp_q.size());
      exp_q.delete();
      name_q.delete();
    end
  endtask

  initial begin : monitor
    exp_t  e;
    string nm;
    forever begin
      @(negedge clk);
      while (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        total++;
        if (e.cyc != cyc || seg !== e.seg || an !== e.an || time_up !== e.tu || blinking !== e.bl) begin
          bad++;
          $display("FAIL %s cyc=%0d/%0d seg=%b/%b an=%b/%b time_up=%b/%b blinking=%b/%b (got/want)",
                   nm, cyc, e.cyc, seg, e.seg, an, e.an, time_up, e.tu, blinking, e.bl);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int c;
    int k;
    vec = '{8'h12, 8'h35, 8'h69, 8'h08, 8'hAF, 8'hE4};
    rst = 1'b1; running = 1'b0; tens_in = 4'd4; ones_in = 4'd7;

    // Reset hold, release, first slot shows ones then 4/7 alternate in 4-clock slots.
    tick(1);
    c = cyc;
    push_blank(c, c + 2, 1'b0, "reset_hold");
    tick(2);
    rst = 1'b0;
    scan_ref = cyc;
    push(scan_ref + 1, dec(4'd0), 2'b10, 1'b0, 1'b0, "first_slot");
    push_live(scan_ref + 2, scan_ref + 16, 4'd4, 4'd7, 1'b0, "scan_47");
    drain();

    // Reset mid-scan is immediate; scan restarts on the ones digit.
    tick(2);
    rst = 1'b1;
    c = cyc;
    push_blank(c, c + 1, 1'b0, "reset_mid_scan");
    tick(1);
    rst = 1'b0;
    scan_ref = cyc;
    push(scan_ref + 1, dec(4'd0), 2'b10, 1'b0, 1'b0, "slot_after_rst");
    push_live(scan_ref + 2, scan_ref + 9, 4'd4, 4'd7, 1'b0, "scan_47_again");
    drain();

    // Decode table, including codes 10..15 as a dash.
    for (int i = 0; i < 6; i++) begin
      tens_in = vec[i][7:4];
      ones_in = vec[i][3:0];
      c = cyc;
      push_live(c + 2, c + 9, vec[i][7:4], vec[i][3:0], 1'b0, "decode");
      tick(8);
    end
    drain();

    // Expiry: 01 -> 00 -> running drops; pulse, then off/on/off/on of 8 clocks each.
    c = cyc;
    running = 1'b1; tens_in = 4'd0; ones_in = 4'd1;
    push_live(c + 2, c + 5, 4'd0, 4'd1, 1'b0, "run_01");
    tick(4);
    tens_in = 4'd0; ones_in = 4'd0;
    push_live(c + 6, c + 9, 4'd0, 4'd0, 1'b0, "run_00");
    tick(4);
    running = 1'b0;
    k = cyc;
    push(k + 2, 7'b1111111, 2'b11, 1'b1, 1'b1, "expiry_pulse");
    push_blank(k + 3, k + 9, 1'b1, "blink_off1");
    push_live(k + 10, k + 17, 4'd0, 4'd0, 1'b1, "blink_on1");
    push_blank(k + 18, k + 25, 1'b1, "blink_off2");
    push_live(k + 26, k + 33, 4'd0, 4'd0, 1'b1, "blink_on2");
    push_live(k + 34, k + 40, 4'd0, 4'd0, 1'b0, "blink_done");
    drain();

    // Abort with digits 25: no pulse, no blink, display keeps showing 25.
    c = cyc;
    running = 1'b1; tens_in = 4'd2; ones_in = 4'd5;
    push_live(c + 2, c + 30, 4'd2, 4'd5, 1'b0, "abort_25");
    tick(4);
    running = 1'b0;
    drain();

    // Restart at blink clock 10 with new digits 19.
    c = cyc;
    running = 1'b1; tens_in = 4'd0; ones_in = 4'd0;
    k = c + 4;
    push_live(c + 2, k + 1, 4'd0, 4'd0, 1'b0, "run_00_b");
    push(k + 2, 7'b1111111, 2'b11, 1'b1, 1'b1, "expiry_pulse_b");
    push_blank(k + 3, k + 9, 1'b1, "blink_off_b");
    push_live(k + 10, k + 13, 4'd0, 4'd0, 1'b1, "blink_on_b");
    push_live(k + 14, k + 40, 4'd1, 4'd9, 1'b0, "restart_19");
    tick(4);
    running = 1'b0;
    tick(12);
    running = 1'b1; tens_in = 4'd1; ones_in = 4'd9;
    drain();

    // Reset at blink clock 5, release with running low: stays idle, no pulse.
    k = cyc;
    running = 1'b0; tens_in = 4'd0; ones_in = 4'd0;
    push_live(k + 1, k + 1, 4'd1, 4'd9, 1'b0, "pre_expiry_c");
    push(k + 2, 7'b1111111, 2'b11, 1'b1, 1'b1, "expiry_pulse_c");
    push_blank(k + 3, k + 6, 1'b1, "blink_off_c");
    tick(7);
    rst = 1'b1;
    push_blank(k + 7, k + 10, 1'b0, "reset_mid_blink");
    tick(3);
    rst = 1'b0;
    scan_ref = cyc;
    push_live(scan_ref + 1, scan_ref + 30, 4'd0, 4'd0, 1'b0, "idle_after_rst");
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/timer_display_ctrl.md
# timer_display_ctrl

Display-side consumer of the game countdown timer. It takes the timer's two BCD digits and its running flag, and drives a two-digit multiplexed active-low 7-segment display. It detects the end of a round (running drops while the count is 00), emits a one-cycle `time_up` pulse, and blinks "00" a fixed number of times before returning to idle. It sits between the countdown timer and the board display pins.

## Interface

- `SCAN_DIV`, default 50000: clock cycles per digit slot (1 kHz digit switching at 50 MHz).
- `BLINK_DIV`, default 25000000: clock cycles per blink half-period (0.5 s at 50 MHz).
- `BLINK_COUNT`, default 3: number of off/on blink cycles after expiry. Must be ≥1.

- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset, asynchronous, active-high.
- `tens_in`  in  4  BCD tens digit from the timer.
- `ones_in`  in  4  BCD ones digit from the timer.
- `running`  in  1  timer counting flag from the timer.
- `seg`  out  7  segments {a,b,c,d,e,f,g}, a = bit 6, active-low.
- `an`  out  2  digit enables, active-low; an[0] = ones digit, an[1] = tens digit.
- `time_up`  out  1  one-cycle pulse on round expiry.
- `blinking`  out  1  high while in BLINK state.

## Operation

- **Input stage.** `tens_in`, `ones_in` and `running` are registered every clock into d1. `running` is registered again into d2.
- **Decode.** 0–9 use the standard active-low patterns: 0 = 0000001, 1 = 1001111, … 8 = 0000000, 9 = 0000100. Codes 10–15 display a dash, 1111110.
- **Scan.**
  - `scan_cnt` counts 0..SCAN_DIV-1 and wraps.
  - At the terminal count, `sel` toggles.
  - `sel=0`: an = 10, seg shows the ones digit.
  - `sel=1`: an = 01, seg shows the tens digit.
  - Scanning runs in every state.
- **FSM states:** IDLE, RUN, BLINK.
  - IDLE → RUN when d1.running = 1.
  - RUN → BLINK when d2.running = 1, d1.running = 0 and d1 digits = 00 (expiry). `time_up` is asserted for exactly this transition cycle.
  - RUN → IDLE when `running` falls with d1 digits ≠ 00 (abort or reset). No `time_up`.
  - BLINK:
    - Entered in the off phase, with `blink_cnt` = 0 and `cycles` = 0.
    - `blink_cnt` counts 0..BLINK_DIV-1. At the terminal count the phase toggles. On each on → off toggle, `cycles` increments.
    - When `cycles` reaches BLINK_COUNT at the end of an on phase, → IDLE.
    - While in the off phase, an = 11 and seg = 1111111. While in the on phase, "00" is shown, not the live inputs.
  - BLINK → RUN immediately if d1.running = 1 (new round). Blink counters clear.
- **Outputs.** `blinking` = (state == BLINK). `seg` and `an` are registered.
- **Reset (async, any time, including mid-blink):**
  - `seg` = 1111111, `an` = 11, `time_up` = 0, `blinking` = 0.
  - State = IDLE; `sel`, `scan_cnt`, `blink_cnt`, `cycles` and d1/d2 = 0.

## Timing

- Input change → `seg`/`an` update: 2 clocks (input register + output register), aligned to the current `sel` slot.
- `running` sampled 0 at edge N (with digits 00, previously 1): `time_up` is high for exactly one cycle, from edge N+1 to N+2. `blinking` rises at edge N+1.
- A digit slot lasts exactly SCAN_DIV clocks. The `an` pattern never has both bits low.
- Blink: first off phase starts at edge N+1 and lasts BLINK_DIV clocks. Total BLINK duration = 2·BLINK_DIV·BLINK_COUNT clocks, then `blinking` falls.
- Simultaneous events:
  - `running` re-rising in the same cycle that BLINK completes: RUN wins.
  - Expiry detected while a scan wrap occurs: both take effect.
- `time_up` never asserts twice per round. A second pulse requires IDLE/BLINK → RUN → expiry again.

## Test plan

Parameters for all scenarios: SCAN_DIV = 4, BLINK_DIV = 8, BLINK_COUNT = 2.

1. **Reset.** Assert `rst` mid-scan → immediately `seg` = 1111111, `an` = 11, `time_up` = 0, `blinking` = 0. After release, the first slot shows ones with an = 10.
2. **Scan and decode.** tens = 4, ones = 7, running = 0 → alternating 4-clock slots: an = 10 / seg = 0001111, then an = 01 / seg = 1001100. Input 4'hA → 1111110.
3. **Expiry.** running = 1 with 0,1 then 0,0, then running = 0 → one `time_up` pulse two edges after sampling. `blinking` high for 32 clocks: off 8, on "00" 8, off 8, on 8. Then IDLE.
4. **Abort.** running 1 → 0 with digits 2,5 → no `time_up`, no blink, state IDLE, display continues showing 25.
5. **Restart during blink.** running = 1 at blink clock 10 → `blinking` falls next cycle, live digits displayed, no further blink phases.
6. **Reset mid-blink.** Assert `rst` at blink clock 5 → outputs at reset values. Release with running = 0 → IDLE, no `time_up`.
